// File: rtl/dz_pkg.sv
// ---------------------------------------------------------------------------
// dz_pkg
// Shared constants for the dot-matrix scan path. The display-side transfer
// block and the scan decoder both import this package so that row/column
// widths, ROM geometry and colour codes cannot drift apart.
//   ROW_W / COL_W   : scan row select width and pixels per row
//   ROM_DEPTH       : number of images held in the shared image ROM
//   ENTRY_W / IDX_W : ROM entry width (8 rows x 8 columns) and index width
//   COLOR_*         : frame colour classification codes
// ---------------------------------------------------------------------------
package dz_pkg;

   localparam int ROW_W     = 8;
   localparam int COL_W     = 8;
   localparam int ROM_DEPTH = 9;
   localparam int ENTRY_W   = ROW_W * COL_W;
   localparam int IDX_W     = 4;

   localparam logic [1:0] COLOR_NONE  = 2'd0;
   localparam logic [1:0] COLOR_GREEN = 2'd1;
   localparam logic [1:0] COLOR_RED   = 2'd2;
   localparam logic [1:0] COLOR_MIXED = 2'd3;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_MATCH   = 2'd1,
      ST_RESULT  = 2'd2
   } dz_state_e;

   // Classify a frame by which colour planes carry any lit pixel.
   function automatic logic [1:0] color_code(input logic [ENTRY_W-1:0] green,
                                             input logic [ENTRY_W-1:0] red);
      logic [1:0] code;
      if ((|green) && (|red)) begin
         code = COLOR_MIXED;
      end else if (|green) begin
         code = COLOR_GREEN;
      end else if (|red) begin
         code = COLOR_RED;
      end else begin
         code = COLOR_NONE;
      end
      return code;
   endfunction

endpackage

// File: rtl/dz_image_rom.sv
// ---------------------------------------------------------------------------
// dz_image_rom
// Combinational image lookup shared with the display path. Each entry packs
// the eight rows of an 8x8 image, row k in bits [8k+7:8k], column 0 in the
// LSB of each row byte. Indices beyond the stored images return all zeros.
//   idx     : image index
//   pattern : 64-bit lit pattern of that image
// ---------------------------------------------------------------------------
module dz_image_rom
   import dz_pkg::*;
(
   input  logic [IDX_W-1:0]   idx,
   output logic [ENTRY_W-1:0] pattern
);

   // Digit glyphs 0..8; the bottom row of every glyph is left dark.
   always_comb begin
      pattern = '0;
      case (idx)
         4'd0:    pattern = 64'h003C6666766E663C;
         4'd1:    pattern = 64'h007E181818183818;
         4'd2:    pattern = 64'h007E60300C06663C;
         4'd3:    pattern = 64'h003C66061C06663C;
         4'd4:    pattern = 64'h000C0C7E6C3C1C0C;
         4'd5:    pattern = 64'h003C6606067C607E;
         4'd6:    pattern = 64'h003C6666667C603C;
         4'd7:    pattern = 64'h00303030180C067E;
         4'd8:    pattern = 64'h003C66663C66663C;
         default: pattern = '0;
      endcase
   end

endmodule

// File: rtl/dz_scan_decoder.sv
// ---------------------------------------------------------------------------
// dz_scan_decoder
// Watches the multiplexed dot-matrix scan, rebuilds a two-colour 8x8 frame,
// looks the lit pattern up in the shared image ROM and reports the image
// number once the same result has been seen for several frames in a row.
//   clk       : system clock
//   dst_n     : asynchronous active-low reset
//   row       : active-low one-hot row select, 8'hFF = blank
//   colg/colr : green / red pixels of the selected row, bit0 = column 0
//   num_out   : last stable decoded image index
//   num_valid : num_out holds a stable ROM-matched value
//   num_upd   : one-clock pulse whenever num_out/num_valid/color change
//   color     : stable frame colour (none / green / red / mixed)
//   scan_err  : sticky, set on a multi-hot row or a dropped frame
// ---------------------------------------------------------------------------
module dz_scan_decoder
   import dz_pkg::*;
#(
   parameter int NUM_IMG       = 9,
   parameter int STABLE_FRAMES = 3,
   parameter int TIMEOUT       = 1000
) (
   input  logic             clk,
   input  logic             dst_n,
   input  logic [ROW_W-1:0] row,
   input  logic [COL_W-1:0] colg,
   input  logic [COL_W-1:0] colr,
   output logic [IDX_W-1:0] num_out,
   output logic             num_valid,
   output logic             num_upd,
   output logic [1:0]       color,
   output logic             scan_err
);

   localparam int                 TMO_W      = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_IMG - 1);
   localparam logic [3:0]         STABLE_MAX = 4'(STABLE_FRAMES);

   dz_state_e          state;
   logic [ROW_W-1:0]   row_q;
   logic [COL_W-1:0]   colg_q;
   logic [COL_W-1:0]   colr_q;
   logic [ENTRY_W-1:0] cap_g;
   logic [ENTRY_W-1:0] cap_r;
   logic [ENTRY_W-1:0] work_g;
   logic [ENTRY_W-1:0] work_r;
   logic [ENTRY_W-1:0] rom_pattern;
   logic [ROW_W-1:0]   seen;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   res_idx;
   logic [IDX_W-1:0]   prev_idx;
   logic               res_hit;
   logic               prev_hit;
   logic [1:0]         prev_color;
   logic [3:0]         stable_cnt;
   logic [TMO_W-1:0]   tmo_cnt;

   logic [3:0]         zero_cnt;
   logic               row_valid;
   logic               row_multi;
   logic [2:0]         row_k;
   logic [ROW_W-1:0]   row_bit;
   logic               timeout_fire;
   logic [1:0]         frame_color;
   logic               res_same;
   logic [3:0]         cnt_next;
   logic [IDX_W-1:0]   next_num;
   logic               out_change;

   dz_image_rom u_rom (
      .idx     (idx),
      .pattern (rom_pattern)
   );

   // Row classification on the registered scan, plus the RESULT-stage
   // bookkeeping: whether this decode repeats the previous one, what the
   // stability counter becomes and whether the visible outputs would move.
   always_comb begin
      zero_cnt  = 4'($countones(~row_q));
      row_valid = (zero_cnt == 4'd1);
      row_multi = (zero_cnt > 4'd1);
      row_k     = '0;
      for (int i = 0; i < ROW_W; i++) begin
         if (!row_q[i]) begin
            row_k = 3'(i);
         end
      end
      row_bit      = ROW_W'(1) << row_k;
      timeout_fire = !row_valid && (tmo_cnt == TMO_LAST);
      frame_color  = color_code(work_g, work_r);
      res_same     = (res_hit == prev_hit) && (res_idx == prev_idx) &&
                     (frame_color == prev_color);
      if (!res_same) begin
         cnt_next = 4'd1;
      end else if (stable_cnt >= STABLE_MAX) begin
         cnt_next = STABLE_MAX;
      end else begin
         cnt_next = stable_cnt + 4'd1;
      end
      next_num   = res_hit ? res_idx : num_out;
      out_change = (next_num != num_out) || (res_hit != num_valid) ||
                   (frame_color != color);
   end

   // Capture, frame assembly, ROM search and output stabilisation. Capture
   // keeps running while a frame is being matched; only hand-over of a new
   // complete frame is refused while the matcher is busy (frame dropped).
   // The timeout section sits last so it wins over a same-clock RESULT.
   always_ff @(posedge clk or negedge dst_n) begin
      if (!dst_n) begin
         state      <= ST_COLLECT;
         row_q      <= '1;
         colg_q     <= '0;
         colr_q     <= '0;
         cap_g      <= '0;
         cap_r      <= '0;
         work_g     <= '0;
         work_r     <= '0;
         seen       <= '0;
         idx        <= '0;
         res_idx    <= '0;
         res_hit    <= 1'b0;
         prev_idx   <= '0;
         prev_hit   <= 1'b0;
         prev_color <= COLOR_NONE;
         stable_cnt <= '0;
         tmo_cnt    <= '0;
         num_out    <= '0;
         num_valid  <= 1'b0;
         num_upd    <= 1'b0;
         color      <= COLOR_NONE;
         scan_err   <= 1'b0;
      end else begin
         row_q   <= row;
         colg_q  <= colg;
         colr_q  <= colr;
         num_upd <= 1'b0;

         if (row_valid) begin
            cap_g[{row_k, 3'b000} +: COL_W] <= colg_q;
            cap_r[{row_k, 3'b000} +: COL_W] <= colr_q;
         end
         if (row_multi) begin
            scan_err <= 1'b1;
         end

         if (seen == '1) begin
            seen <= row_valid ? row_bit : '0;
            if (state == ST_COLLECT) begin
               work_g <= cap_g;
               work_r <= cap_r;
               idx    <= '0;
               state  <= ST_MATCH;
            end else begin
               scan_err <= 1'b1;
            end
         end else if (row_valid) begin
            seen <= seen | row_bit;
         end

         if (row_valid || timeout_fire) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end

         case (state)
            ST_MATCH: begin
               if ((work_g | work_r) == rom_pattern) begin
                  res_hit <= 1'b1;
                  res_idx <= idx;
                  state   <= ST_RESULT;
               end else if (idx == LAST_IDX) begin
                  res_hit <= 1'b0;
                  res_idx <= '0;
                  state   <= ST_RESULT;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_RESULT: begin
               stable_cnt <= cnt_next;
               if (!res_same) begin
                  prev_hit   <= res_hit;
                  prev_idx   <= res_idx;
                  prev_color <= frame_color;
               end
               if (cnt_next == STABLE_MAX) begin
                  num_out   <= next_num;
                  num_valid <= res_hit;
                  color     <= frame_color;
                  num_upd   <= out_change;
               end
               state <= ST_COLLECT;
            end
            default: ;
         endcase

         if (timeout_fire) begin
            seen       <= '0;
            stable_cnt <= '0;
            if (num_valid) begin
               num_valid <= 1'b0;
               num_upd   <= 1'b1;
            end
         end
      end
   end

endmodule
